// File: rtl/tts_pkg.sv
// ---------------------------------------------------------------------------
// tts_pkg -- shared types and constants for the truth-table sequencer.
//   tts_state_e : sequencer FSM states (IDLE, SETTLE, SAMPLE, FINISH)
//   MAX_IN      : widest supported input count (vec width)
//   TABLE_W     : captured-response table width (2**MAX_IN)
//   CNT_W       : ones counter width (must hold TABLE_W itself)
//   SETTLE_W    : settle timer width (SETTLE range 0..7)
// ---------------------------------------------------------------------------
package tts_pkg;

    localparam int MAX_IN   = 4;
    localparam int TABLE_W  = 16;
    localparam int CNT_W    = 5;
    localparam int SETTLE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tts_state_e;

    // Highest legal index for a given input count, in 4-bit index arithmetic.
    function automatic logic [MAX_IN-1:0] last_index(input int n_in);
        return MAX_IN'((1 << n_in) - 1);
    endfunction

endpackage

// File: rtl/truth_table_seq_if.sv
// ---------------------------------------------------------------------------
// truth_table_seq_if -- bus between the sequencer and the logic under test.
//   start      : request a full truth-table sweep
//   resp       : response of the combinational function under test
//   vec        : stimulus, current index (upper unused bits 0)
//   busy       : sweep in progress
//   done       : one-cycle completion pulse
//   resp_table : captured responses, bit i = resp for index i
//                ("table" is a reserved word in SystemVerilog)
//   ones_cnt   : number of indices that answered 1
// With TTS_CHECK_EN defined, also carries:
//   exp        : expected table
//   mismatch   : sticky mismatch flag
//   first_fail : index of the first mismatch
// modport master = sequencer side, modport slave = stimulus/target side.
// ---------------------------------------------------------------------------
interface truth_table_seq_if;
    import tts_pkg::*;

    logic                start;
    logic                resp;
    logic [MAX_IN-1:0]   vec;
    logic                busy;
    logic                done;
    logic [TABLE_W-1:0]  resp_table;
    logic [CNT_W-1:0]    ones_cnt;
`ifdef TTS_CHECK_EN
    logic [TABLE_W-1:0]  exp;
    logic                mismatch;
    logic [MAX_IN-1:0]   first_fail;

    modport master (
        input  start, resp, exp,
        output vec, busy, done, resp_table, ones_cnt, mismatch, first_fail
    );
    modport slave (
        output start, resp, exp,
        input  vec, busy, done, resp_table, ones_cnt, mismatch, first_fail
    );
`else
    modport master (
        input  start, resp,
        output vec, busy, done, resp_table, ones_cnt
    );
    modport slave (
        output start, resp,
        input  vec, busy, done, resp_table, ones_cnt
    );
`endif

endinterface

// File: rtl/tts_settle_timer.sv
// ---------------------------------------------------------------------------
// tts_settle_timer -- down-counter timing the settle wait of each vector.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   load     : load load_val (issued on the edge that enters the wait)
//   load_val : number of wait cycles
//   expire   : high during the last wait cycle (count == 1), once per load
// ---------------------------------------------------------------------------
module tts_settle_timer
    import tts_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expire
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count is loaded with the wait length on entry, so the first wait
    // cycle sees load_val and the final one sees 1.
    assign expire = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_seq.sv
// ---------------------------------------------------------------------------
// truth_table_seq -- walks every input combination of a combinational
// function, waits SETTLE cycles per vector, samples its response into a
// table and counts the ones.
// Parameters:
//   N_IN   : driven inputs (1..4)
//   SETTLE : wait cycles between driving a vector and sampling (0..7)
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : truth_table_seq_if.master (start/resp in, vec/busy/done/
//            resp_table/ones_cnt out)
// Optional feature macro TTS_CHECK_EN adds exp/mismatch/first_fail on the
// bus and compares each sampled response against exp.
// ---------------------------------------------------------------------------
module truth_table_seq
    import tts_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    truth_table_seq_if.master bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETTLE = ST_SETTLE;
    localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
    localparam logic [1:0] S_FINISH = ST_FINISH;

    localparam logic [MAX_IN-1:0]   LAST_IDX   = last_index(N_IN);
    localparam logic [SETTLE_W-1:0] SETTLE_CYC = SETTLE_W'(SETTLE);
    // With no settle wait, each new vector goes straight to sampling.
    localparam logic [1:0]          S_VECTOR   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    logic [1:0]         state_q, state_d;
    logic [MAX_IN-1:0]  idx_q, idx_d;
    logic [TABLE_W-1:0] table_q, table_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               timer_load;
    logic               timer_expire;
`ifdef TTS_CHECK_EN
    logic               mismatch_q, mismatch_d;
    logic [MAX_IN-1:0]  first_fail_q, first_fail_d;
`endif

    tts_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_CYC),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        table_d    = table_q;
        ones_d     = ones_q;
        timer_load = 1'b0;
`ifdef TTS_CHECK_EN
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_VECTOR;
                    idx_d      = '0;
                    table_d    = '0;
                    ones_d     = '0;
                    timer_load = 1'b1;
`ifdef TTS_CHECK_EN
                    mismatch_d   = 1'b0;
                    first_fail_d = '0;
`endif
                end
            end
            S_SETTLE: begin
                if (timer_expire) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                table_d[idx_q] = bus.resp;
                ones_d         = ones_q + CNT_W'(bus.resp);
`ifdef TTS_CHECK_EN
                // Only the first disagreement records its index.
                if ((bus.resp != bus.exp[idx_q]) && !mismatch_q) begin
                    mismatch_d   = 1'b1;
                    first_fail_d = idx_q;
                end
`endif
                // Compare before incrementing so the index never wraps.
                if (idx_q < LAST_IDX) begin
                    idx_d      = idx_q + MAX_IN'(1);
                    state_d    = S_VECTOR;
                    timer_load = 1'b1;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
`ifdef TTS_CHECK_EN
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            ones_q  <= ones_d;
`ifdef TTS_CHECK_EN
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
`endif
        end
    end

    // idx_q never exceeds LAST_IDX, so unused upper vec bits stay 0.
    assign bus.vec        = idx_q;
    assign bus.busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign bus.done       = (state_q == S_FINISH);
    assign bus.resp_table = table_q;
    assign bus.ones_cnt   = ones_q;
`ifdef TTS_CHECK_EN
    assign bus.mismatch   = mismatch_q;
    assign bus.first_fail = first_fail_q;
`endif

endmodule

// File: doc/truth_table_seq.md
TRUTH_TABLE_SEQ -- requirements
Module: truth_table_seq

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of driven inputs (legal 1..4).
REQ-002 SHALL have parameter SETTLE, default 1, number of wait cycles between driving a vector and sampling its response (legal 0..7).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request a full truth-table sweep.
REQ-007 resp  input  1  response of the combinational function under test.
REQ-008 vec  output  4  stimulus. vec[N_IN-1:0] = current index, MSB = first operand (a), upper bits 0.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 table  output  16  captured responses; table[i] = resp for index i; bits at or above 2^N_IN are 0.
REQ-012 ones_cnt  output  5  count of indices with resp=1.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE, FINISH.
REQ-014 IDLE with start=1 SHALL move to SETTLE (or to SAMPLE if SETTLE=0), set index=0, and clear table and ones_cnt, all on the same edge.
REQ-015 SETTLE SHALL hold vec stable for exactly SETTLE cycles, then move to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle; on its closing edge table[index] SHALL take resp and ones_cnt SHALL increment if resp=1.
REQ-017 After SAMPLE, if index < 2^N_IN-1, the FSM SHALL increment index and return to SETTLE (or SAMPLE if SETTLE=0); otherwise it SHALL go to FINISH.
REQ-018 Each vector SHALL occupy SETTLE+1 cycles, and done SHALL assert 2^N_IN*(SETTLE+1) cycles after the start-accept edge.
REQ-019 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and FINISH.
REQ-020 done SHALL be 1 only in FINISH; FINISH SHALL always return to IDLE after one cycle.
REQ-021 start SHALL be ignored in SETTLE, SAMPLE and FINISH, with no queuing.
REQ-022 table and ones_cnt SHALL hold their values after done until the next accepted start.
REQ-023 Index arithmetic SHALL be 4-bit and SHALL never wrap past 2^N_IN-1.

Reset
REQ-024 rst_n=0 SHALL force state=IDLE, vec=0, busy=0, done=0, table=0, ones_cnt=0 on the next edge, including during a sweep.
REQ-025 A sweep aborted by reset SHALL NOT produce a done pulse.

Configuration
REQ-026 With macro TTS_CHECK_EN defined, the block SHALL add input exp (16 bits, expected table), output mismatch (1 bit) and output first_fail (4 bits).
REQ-027 Under TTS_CHECK_EN, mismatch SHALL be sticky and set on the SAMPLE edge where resp != exp[index]; first_fail SHALL capture the index of the first mismatch.
REQ-028 Under TTS_CHECK_EN, mismatch and first_fail SHALL be cleared by reset and by start acceptance.
REQ-029 Without TTS_CHECK_EN, the exp, mismatch and first_fail ports SHALL be absent and no comparison logic SHALL be built.

Structure
REQ-030 Package tts_pkg SHALL hold the state enum, MAX_IN=4 and TABLE_W=16.
REQ-031 The SETTLE wait SHALL be a sub-module tts_settle_timer (load, count down, expire pulse); all other logic SHALL stay in truth_table_seq.

Verification
REQ-032 N_IN=2, SETTLE=0, resp=XOR(vec[1],vec[0]), start pulse -> table=16'h0006, ones_cnt=2, done 4 cycles after accept.
REQ-033 N_IN=3, SETTLE=1, resp=ab|ac|b&~c -> table=16'h00E4, ones_cnt=4, done 16 cycles after accept.
REQ-034 N_IN=4, SETTLE=2, resp=d|(c&~(a&b&c)) -> table=16'hAEEE, ones_cnt=11, done 48 cycles after accept.
REQ-035 Pulse start again mid-sweep -> ignored; single done; table unchanged from the REQ-034 result.
REQ-036 rst_n=0 at index 5 -> all outputs 0 next cycle, no done; a following start runs a full correct sweep.
REQ-037 TTS_CHECK_EN, REQ-034 stimulus with exp=16'hAEEF -> mismatch=1, first_fail=0, and the sweep completes.
